window_minmax_tracker: RTL and testbench

WINDOW_MINMAX_TRACKER -- requirements
Module: window_minmax_tracker

---
 rtl/window_minmax_tracker_pkg.sv | 16 +
 rtl/window_minmax_tracker_mag_compare.sv | 20 ++
 rtl/window_minmax_tracker.sv | 142 ++++++++++++++
 tb/tb_window_minmax_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/window_minmax_tracker_pkg.sv
// Shared definitions for the window min/max tracker: FSM state encoding and
// the helper that sizes the in-window position counter.
package window_minmax_tracker_pkg;

  // ACCUM collects samples, HOLD presents a finished window result
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } stateT;

  // Bits needed to hold window positions 0..winLen-1 (never less than one bit)
  function automatic int idxWidth(input int winLen);
    return (winLen <= 2) ? 1 : $clog2(winLen);
  endfunction

endpackage

// File: rtl/window_minmax_tracker_mag_compare.sv
// Unsigned magnitude comparator used for both the running-max and
// running-min decisions. Purely combinational; exactly one output is high.
module mag_compare #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              gt,
  output logic              eq,
  output logic              lt
);

  // Unsigned relation of a to b; operands are plain logic so no sign applies
  always_comb begin
    gt = (i_a > i_b);
    eq = (i_a == i_b);
    lt = (i_a < i_b);
  end

endmodule

// File: rtl/window_minmax_tracker.sv
// Window min/max tracker: collects WIN_LEN unsigned samples through a
// valid/ready handshake, then holds the largest and smallest sample until the
// consumer takes the result. Windows never overlap.
// Optional feature: define WINDOW_MINMAX_IDX_EN to add out_idx_max/out_idx_min,
// the 0-based window positions of the first occurrence of the max/min.
module window_minmax_tracker
  import window_minmax_tracker_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int WIN_LEN = 16,
  localparam int IDX_W  = idxWidth(WIN_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min
`ifdef WINDOW_MINMAX_IDX_EN
  ,
  output logic [IDX_W-1:0]  out_idx_max,
  output logic [IDX_W-1:0]  out_idx_min
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  stateT             r_state;
  stateT             w_nextState;
  logic              r_inReady;
  logic              r_outValid;
  logic              w_nextInReady;
  logic              w_nextOutValid;
  logic [IDX_W-1:0]  r_count;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_min;
  logic              w_accept;
  logic              w_last;
  logic              w_outFire;
  logic              w_maxGt, w_maxEq, w_maxLt;
  logic              w_minGt, w_minEq, w_minLt;
  logic              w_updMax;
  logic              w_updMin;

  assign w_accept  = in_valid & r_inReady;
  assign w_outFire = out_ready & r_outValid;
  assign w_last    = (r_count == LAST_IDX);

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_max   = r_max;
  assign out_min   = r_min;

  mag_compare #(.DATA_W(DATA_W)) u_cmpMax (
    .i_a (in_data),
    .i_b (r_max),
    .gt  (w_maxGt),
    .eq  (w_maxEq),
    .lt  (w_maxLt)
  );

  mag_compare #(.DATA_W(DATA_W)) u_cmpMin (
    .i_a (in_data),
    .i_b (r_min),
    .gt  (w_minGt),
    .eq  (w_minEq),
    .lt  (w_minLt)
  );

  // A tie (eq) must never replace the stored value so the first occurrence wins
  assign w_updMax = w_maxGt & ~(w_maxEq | w_maxLt);
  assign w_updMin = w_minLt & ~(w_minEq | w_minGt);

  // State register plus registered handshake flags; both flags are 0 in reset
  // so in_ready only rises on the first edge after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ACCUM;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= w_nextInReady;
      r_outValid <= w_nextOutValid;
    end
  end

  // Next state: finish a window on the last handshake, release it on out_fire
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && w_last) w_nextState = ST_HOLD;
      ST_HOLD:  if (w_outFire)          w_nextState = ST_ACCUM;
      default:  w_nextState = ST_ACCUM;
    endcase
    w_nextInReady  = (w_nextState == ST_ACCUM);
    w_nextOutValid = (w_nextState == ST_HOLD);
  end

  // Running max/min and window position; the first sample of a window loads both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_max   <= '0;
      r_min   <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + IDX_W'(1);
      if (r_count == '0) begin
        r_max <= in_data;
        r_min <= in_data;
      end else begin
        if (w_updMax) r_max <= in_data;
        if (w_updMin) r_min <= in_data;
      end
    end
  end

`ifdef WINDOW_MINMAX_IDX_EN
  logic [IDX_W-1:0] r_idxMax;
  logic [IDX_W-1:0] r_idxMin;

  assign out_idx_max = r_idxMax;
  assign out_idx_min = r_idxMin;

  // Capture the window position whenever the running max/min is (re)loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idxMax <= '0;
      r_idxMin <= '0;
    end else if (w_accept) begin
      if (r_count == '0 || w_updMax) r_idxMax <= r_count;
      if (r_count == '0 || w_updMin) r_idxMin <= r_count;
    end
  end
`else
  // Index tracking disabled: no position registers or ports exist
`endif

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Directed bench for window_minmax_tracker (DATA_W=8, WIN_LEN=4).
// Index outputs are connected and checked only when WINDOW_MINMAX_IDX_EN is defined.
module tb_window_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
`ifdef WINDOW_MINMAX_IDX_EN
  logic [1:0] out_idx_max;
  logic [1:0] out_idx_min;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           name;
    logic [0:3][7:0] samples;
    logic [7:0]      expMax;
    logic [7:0]      expMin;
    logic [1:0]      expIdxMax;
    logic [1:0]      expIdxMin;
  } vecT;

  vecT vecs[4];

  window_minmax_tracker #(.DATA_W(8), .WIN_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min)
`ifdef WINDOW_MINMAX_IDX_EN
    ,
    .out_idx_max (out_idx_max),
    .out_idx_min (out_idx_min)
`endif
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offer one sample and return on the falling edge right after it is accepted
  task automatic applyStimulus(input logic [7:0] d);
    int waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL inReadyTimeout: in_ready got 0 after %0d cycles, expected 1", waitCycles);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Send a full window and check the result one cycle after the last handshake
  task automatic runWindow(input string tag, input logic [0:3][7:0] s,
                           input logic [7:0] eMax, input logic [7:0] eMin,
                           input logic [1:0] eIdxMax, input logic [1:0] eIdxMin);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) checkOutput({tag, ".validBeforeLast"}, out_valid, 1'b0);
      applyStimulus(s[k]);
    end
    checkOutput({tag, ".outValid"}, out_valid, 1'b1);
    checkOutput({tag, ".inReadyLow"}, in_ready, 1'b0);
    checkOutput({tag, ".max"}, out_max, eMax);
    checkOutput({tag, ".min"}, out_min, eMin);
`ifdef WINDOW_MINMAX_IDX_EN
    checkOutput({tag, ".idxMax"}, out_idx_max, eIdxMax);
    checkOutput({tag, ".idxMin"}, out_idx_min, eIdxMin);
`else
    if (eIdxMax != eIdxMin) begin end
`endif
  endtask

  // Take the pending result and confirm the block reopens the next cycle
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".validDropped"}, out_valid, 1'b0);
    checkOutput({tag, ".inReadyBack"}, in_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{name:"basic",  samples:{8'd5,   8'd200, 8'd3,   8'd77},
                expMax:8'd200, expMin:8'd3,   expIdxMax:2'd1, expIdxMin:2'd2};
    vecs[1] = '{name:"equal",  samples:{8'd9,   8'd9,   8'd9,   8'd9},
                expMax:8'd9,   expMin:8'd9,   expIdxMax:2'd0, expIdxMin:2'd0};
    vecs[2] = '{name:"bounds", samples:{8'd0,   8'd255, 8'd255, 8'd0},
                expMax:8'd255, expMin:8'd0,   expIdxMax:2'd1, expIdxMin:2'd0};
    vecs[3] = '{name:"mixed",  samples:{8'd100, 8'd50,  8'd150, 8'd50},
                expMax:8'd150, expMin:8'd50,  expIdxMax:2'd2, expIdxMin:2'd1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.inReady", in_ready, 1'b0);
    checkOutput("reset.outValid", out_valid, 1'b0);
    checkOutput("reset.max", out_max, 8'd0);
    checkOutput("reset.min", out_min, 8'd0);
`ifdef WINDOW_MINMAX_IDX_EN
    checkOutput("reset.idxMax", out_idx_max, 2'd0);
    checkOutput("reset.idxMin", out_idx_min, 2'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.inReadyAfter", in_ready, 1'b1);

    for (int v = 0; v < 4; v++) begin
      runWindow(vecs[v].name, vecs[v].samples, vecs[v].expMax, vecs[v].expMin,
                vecs[v].expIdxMax, vecs[v].expIdxMin);
      releaseResult(vecs[v].name);
    end

    $display("[TB] back-pressure: result held while out_ready stays low");
    runWindow("hold", {8'd20, 8'd30, 8'd10, 8'd40}, 8'd40, 8'd10, 2'd3, 2'd2);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("hold.outValid", out_valid, 1'b1);
      checkOutput("hold.inReady", in_ready, 1'b0);
      checkOutput("hold.max", out_max, 8'd40);
      checkOutput("hold.min", out_min, 8'd10);
    end
    in_valid = 1'b0;
    releaseResult("hold");
    runWindow("afterHold", {8'd7, 8'd8, 8'd6, 8'd7}, 8'd8, 8'd6, 2'd1, 2'd2);
    releaseResult("afterHold");

    $display("[TB] bubbles: 10,_,_,4,_,60,8");
    begin
      logic [6:0]      validPat;
      logic [0:6][7:0] dataPat;
      validPat = 7'b1001011;
      dataPat  = {8'd10, 8'd0, 8'd0, 8'd4, 8'd0, 8'd60, 8'd8};
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (k == 6) checkOutput("bubble.validBeforeLast", out_valid, 1'b0);
        in_valid = validPat[6-k];
        in_data  = dataPat[k];
      end
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("bubble.outValid", out_valid, 1'b1);
      checkOutput("bubble.max", out_max, 8'd60);
      checkOutput("bubble.min", out_min, 8'd4);
`ifdef WINDOW_MINMAX_IDX_EN
      checkOutput("bubble.idxMax", out_idx_max, 2'd2);
      checkOutput("bubble.idxMin", out_idx_min, 2'd1);
`endif
      releaseResult("bubble");
    end

    $display("[TB] reset mid-window after samples 1,2");
    applyStimulus(8'd1);
    applyStimulus(8'd2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRst.inReady", in_ready, 1'b0);
    checkOutput("midRst.max", out_max, 8'd0);
    rst = 1'b0;
    runWindow("midRst", {8'd50, 8'd40, 8'd30, 8'd20}, 8'd50, 8'd20, 2'd0, 2'd3);

    $display("[TB] reset while a result is pending");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("holdRst.outValid", out_valid, 1'b0);
    checkOutput("holdRst.min", out_min, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("holdRst.inReadyAfter", in_ready, 1'b1);
    runWindow("postRst", {8'd5, 8'd200, 8'd3, 8'd77}, 8'd200, 8'd3, 2'd1, 2'd2);
    releaseResult("postRst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
